// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and memory-wait stalls, redirect flushes.
// Optional HAZARD_PERF_EN adds stall/flush performance counters; otherwise they read as zero.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             StallEM,
  output logic             FlushW,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t state_q, state_d;
  logic   redirect_pend;
  logic   lw_stall, mem_stall, redir;

  // Memory stage wins over Writeback because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic we_m, input logic [4:0] rd_w,
                                         input logic we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign mem_stall = MemReqM && !MemReadyM;
  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign redir     = PCSrcE || redirect_pend;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (MemReqM && !MemReadyM) state_d = MEM_WAIT;
      MEM_WAIT: if (MemReadyM)             state_d = RUN;
      default:                             state_d = RUN;
    endcase
  end

  // A redirect seen while frozen is replayed on the first unfrozen cycle.
  always_ff @(posedge clk) begin
    if (!rst)           redirect_pend <= 1'b0;
    else if (mem_stall) redirect_pend <= redirect_pend | PCSrcE;
    else                redirect_pend <= 1'b0;
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    StallEM   = 1'b0;
    FlushW    = 1'b0;
    if (!rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (mem_stall) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallEM = 1'b1;
        FlushW  = 1'b1;
      end else begin
        FlushD = redir;
        FlushE = redir || lw_stall;
        StallD = lw_stall && !redir;
        StallF = lw_stall && !PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF) stall_cnt <= stall_cnt + CNT_W'(1);
      if (FlushE) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed corner cases, then randomized traffic against a reference model.
module tb_hazard_ctrl;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE, StallEM, FlushW;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit               m_pend = 1'b0;
  logic [CNT_W-1:0] m_stall_cnt = '0;
  logic [CNT_W-1:0] m_flush_cnt = '0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .RdW(RdW), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallEM(StallEM), .FlushW(FlushW),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallEM, FlushW}
  function automatic logic [9:0] m_out();
    bit mem, lw, r;
    if (!rst) return {4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    mem = MemReqM && !MemReadyM;
    lw  = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (mem) return {m_fwd(Rs1E), m_fwd(Rs2E), 6'b110011};
    r = PCSrcE || m_pend;
    return {m_fwd(Rs1E), m_fwd(Rs2E), lw && !PCSrcE, lw && !r, r, r || lw, 1'b0, 1'b0};
  endfunction

  task automatic eval();
    logic [9:0] e;
    #2;
    e = m_out();
    check("outputs", {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallEM, FlushW}, e);
`ifdef HAZARD_PERF_EN
    check("stall_cnt", StallCnt, m_stall_cnt);
    check("flush_cnt", FlushCnt, m_flush_cnt);
`else
    check("stall_cnt_tied", StallCnt, 0);
    check("flush_cnt_tied", FlushCnt, 0);
`endif
  endtask

  task automatic tick();
    logic [9:0] e;
    e = m_out();
    @(posedge clk);
    if (!rst) begin
      m_pend = 1'b0;
      m_stall_cnt = '0;
      m_flush_cnt = '0;
    end else begin
      if (e[5]) m_stall_cnt = m_stall_cnt + 1;
      if (e[2]) m_flush_cnt = m_flush_cnt + 1;
      m_pend = (MemReqM && !MemReadyM) ? (m_pend || PCSrcE) : 1'b0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW} = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();

    // Reset values
    eval();
    check("rst_fwd", {ForwardAE, ForwardBE}, 4'b0000);
    check("rst_flush", {FlushD, FlushE, FlushW}, 3'b111);
    check("rst_stall", {StallF, StallD, StallEM}, 3'b000);
    tick();
    rst = 1'b1;

    // Forwarding priority
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
    eval();
    check("fwd_mem_prio", ForwardAE, 2'b10);
    check("fwd_b_mem_prio", ForwardBE, 2'b10);
    RdM = 0;
    eval();
    check("fwd_wb_when_rdm0", ForwardAE, 2'b01);
    tick();
    clear_inputs();

    // Load-use stall
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    eval();
    check("lw_stall", {StallF, StallD, FlushE, FlushD}, 4'b1110);
    tick();

    // Load-use together with a redirect
    PCSrcE = 1;
    eval();
    check("lw_redir", {FlushD, FlushE, StallF, StallD}, 4'b1100);
    tick();
    clear_inputs();

    // Memory wait with a taken branch, then completion
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      eval();
      check("memwait", {StallF, StallD, StallEM, FlushW, FlushD}, 5'b11110);
      tick();
    end
    MemReadyM = 1; PCSrcE = 0;
    eval();
    check("mem_done_redir", {FlushD, FlushE}, 2'b11);
    tick();
    clear_inputs();
    eval();
    check("redir_cleared", {FlushD, FlushE}, 2'b00);
    tick();

    // Reset in the middle of a memory wait with a pending redirect
    MemReqM = 1; PCSrcE = 1;
    eval(); tick();
    eval(); tick();
    rst = 1'b0;
    eval();
    tick();
    rst = 1'b1;
    clear_inputs();
    eval();
    check("post_rst_clean", {StallF, StallD, FlushD, FlushE, StallEM, FlushW}, 6'b000000);
`ifdef HAZARD_PERF_EN
    check("post_rst_cnt", {StallCnt, FlushCnt}, 64'd0);
`endif
    tick();

    // Randomized traffic on a small register set so matches are frequent
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 39) != 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      MemReqM    = ($urandom_range(0, 2) != 0);
      MemReadyM  = 1'($urandom);
      eval();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of performance counters (used only with HAZARD_PERF_EN).
REQ-002 SHALL have clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have Rs1D  in  5  source register 1 of instruction in Decode.
REQ-005 SHALL have Rs2D  in  5  source register 2 of instruction in Decode.
REQ-006 SHALL have Rs1E  in  5  source register 1 held in ID/EX.
REQ-007 SHALL have Rs2E  in  5  source register 2 held in ID/EX.
REQ-008 SHALL have RdE  in  5  destination register held in ID/EX.
REQ-009 SHALL have ResultSrcE  in  2  result select in Execute; 2'b01 marks a load.
REQ-010 SHALL have PCSrcE  in  1  taken branch/jump resolved in Execute.
REQ-011 SHALL have RdM  in  5  destination register in Memory.
REQ-012 SHALL have RegWriteM  in  1  register-write enable in Memory.
REQ-013 SHALL have MemReqM  in  1  data-memory access active in Memory.
REQ-014 SHALL have MemReadyM  in  1  data memory completes access this cycle.
REQ-015 SHALL have RdW  in  5  destination register in Writeback.
REQ-016 SHALL have RegWriteW  in  1  register-write enable in Writeback.
REQ-017 SHALL have ForwardAE  out  2  operand A select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-018 SHALL have ForwardBE  out  2  operand B select, same encoding.
REQ-019 SHALL have StallF  out  1  hold PC register.
REQ-020 SHALL have StallD  out  1  hold IF/ID register.
REQ-021 SHALL have FlushD  out  1  clear IF/ID register.
REQ-022 SHALL have FlushE  out  1  clear ID/EX register (bubble).
REQ-023 SHALL have StallEM  out  1  hold ID/EX and EX/MEM registers.
REQ-024 SHALL have FlushW  out  1  bubble into MEM/WB register.
REQ-025 SHALL have StallCnt, FlushCnt  out  CNT_W each  performance counters (HAZARD_PERF_EN only).

Function
REQ-026 Forwarding SHALL be combinational: ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 00; Memory priority over Writeback; ForwardBE identical with Rs2E.
REQ-027 lwStall SHALL be ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-028 FSM states SHALL be RUN and MEM_WAIT, registered, one transition per cycle max.
REQ-029 RUN -> MEM_WAIT when MemReqM && !MemReadyM; MEM_WAIT -> RUN when MemReadyM; MemReqM && MemReadyM in RUN is single-cycle, no transition.
REQ-030 memStall (combinational) SHALL be MemReqM && !MemReadyM, in either state.
REQ-031 While memStall: StallF=StallD=StallEM=1, FlushW=1, FlushD=FlushE=0; lwStall and PCSrcE SHALL NOT cause flushes.
REQ-032 While memStall and PCSrcE=1, redirect_pend register SHALL set; cleared on the first cycle with memStall=0.
REQ-033 Without memStall: redir = PCSrcE || redirect_pend; FlushD=redir; FlushE=redir || lwStall; StallD=lwStall && !redir; StallF=lwStall && !PCSrcE; StallEM=0; FlushW=0.
REQ-034 Redirect and load-use in same cycle SHALL resolve as redirect: FlushD=FlushE=1, StallD=0.
REQ-035 Outputs SHALL depend only on current inputs and registered state; zero cycles latency.

Reset
REQ-036 While rst=0: state=RUN, redirect_pend=0, counters=0; outputs Forward*=00, StallF=StallD=StallEM=0, FlushD=FlushE=FlushW=1.
REQ-037 Reset during MEM_WAIT SHALL abort the wait next edge; a pending redirect SHALL be discarded.

Configuration
REQ-038 With HAZARD_PERF_EN defined: StallCnt increments each cycle StallF=1, FlushCnt increments each cycle FlushE=1, both wrap modulo 2^CNT_W.
REQ-039 Without HAZARD_PERF_EN: no counter registers; StallCnt and FlushCnt SHALL be tied to 0.

Verification
REQ-040 RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10; RdM=0 same case -> ForwardAE=01.
REQ-041 ResultSrcE=01,RdE=7,Rs2D=7,PCSrcE=0 -> one cycle StallF=StallD=FlushE=1, FlushD=0.
REQ-042 Load-use plus PCSrcE=1 same cycle -> FlushD=FlushE=1, StallF=StallD=0.
REQ-043 MemReqM=1,MemReadyM=0 for 3 cycles with PCSrcE=1 -> 3 cycles StallF/StallD/StallEM/FlushW=1, FlushD=0; MemReadyM=1 cycle -> FlushD=FlushE=1, state RUN.
REQ-044 rst=0 mid MEM_WAIT with pending redirect -> next cycle after rst=1 with no hazard: all stalls/flushes 0; with HAZARD_PERF_EN counters read 0.
